opb_master_single: RTL and testbench
====================================

OPB_MASTER_SINGLE -- requirements
Module: opb_master_single

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the reset port is named OPB_Rst_n.
REQ-002 SHALL take the following parameters (name, default, meaning):
- C_OPB_AWIDTH, 32, address width.
- C_OPB_DWIDTH, 32, data width.
- C_MAX_RETRIES, 4, number of OPB_retry responses tolerated per command before an error is reported (legal range 1..15).
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- OPB_Clk  in  1  clock.
- OPB_Rst_n  in  1  async active-low reset.
- cmd_valid  in  1  user command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  [31:0]  byte address.
- cmd_data  in  [31:0]  write data.
- cmd_be  in  [3:0]  byte enables.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  [31:0]  read data, 0 for writes.
- rsp_err  out  1  transfer failed.
- M_request  out  1  bus request.
- M_select  out  1  master select.
- M_RNW  out  1  read/not-write.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- M_seqAddr  out  1  sequential address.
- M_busLock  out  1  bus lock.
- OPB_MGrant  in  1  grant.
- OPB_DBus  in  [0:31]  read data.
- OPB_xferAck  in  1  transfer acknowledge.
- OPB_errAck  in  1  error acknowledge.
- OPB_retry  in  1  retry.
- OPB_timeout  in  1  arbiter timeout.
REQ-004 SHALL map user bit 31 to OPB bit 0 (bit reversal) on all address, data and byte-enable buses.

Function
REQ-005 SHALL implement four states: IDLE, REQ, XFER, RESP; all outputs SHALL be registered.
REQ-006 IDLE: cmd_ready SHALL be 1. The command is latched when cmd_valid and cmd_ready are both high, and the state then goes to REQ. cmd_ready SHALL be 0 in all other states.
REQ-007 REQ: M_request SHALL be 1. When OPB_MGrant is sampled at 1, the next state is XFER and M_request falls in the same edge.
REQ-008 XFER: M_select SHALL be 1 and M_RNW/M_ABus/M_BE SHALL hold the latched command. M_DBus SHALL carry the write data only when M_RNW = 0, otherwise 0.
REQ-009 While M_select = 0, M_RNW, M_ABus, M_BE and M_DBus SHALL all be 0 (OR-bus rule). M_seqAddr SHALL always be 0.
REQ-010 XFER exit priority, evaluated on each edge:
- OPB_errAck or OPB_timeout: RESP with error.
- else OPB_xferAck: RESP without error; OPB_DBus is captured when reading.
- else OPB_retry: back to REQ and increment the retry count.
- else remain in XFER.
REQ-011 If OPB_retry would make the retry count exceed C_MAX_RETRIES, the block SHALL go to RESP with error instead of REQ.
REQ-012 The retry counter SHALL clear at command acceptance.
REQ-013 Between xferAck and rsp_valid there SHALL be exactly one cycle.
REQ-014 RESP: rsp_valid SHALL be 1 for exactly one cycle, after which the state returns to IDLE.
REQ-015 rsp_data and rsp_err SHALL hold their values until the next rsp_valid.
REQ-016 Minimum command-to-response latency is 4 cycles (accept, REQ with grant, XFER with ack, RESP). The next command can be accepted on the cycle after rsp_valid.
REQ-017 Ack, error, retry and timeout inputs arriving outside XFER SHALL be ignored.

Reset
REQ-018 Asserting OPB_Rst_n low SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- cmd_ready = 1;
- every other output to 0;
- the retry counter to 0.
REQ-019 A reset during REQ or XFER SHALL abandon the transfer with no rsp_valid. M_select and M_request SHALL drop asynchronously.

Configuration
REQ-020 With macro OPB_MASTER_BUSLOCK_EN defined, M_busLock SHALL be 1 from the first REQ cycle until the cycle after leaving XFER for RESP, across all retries.
REQ-021 Without OPB_MASTER_BUSLOCK_EN, M_busLock SHALL be constant 0.

Verification
REQ-022 Read: addr 0x01000100, grant in 1 cycle, xferAck with OPB_DBus bit0..31 = 0x12345678 reversed -> rsp_valid 4 cycles after accept, rsp_data 0x12345678, rsp_err 0.
REQ-023 Write: data 0xDEADBEEF, be 0xF, grant delayed 5 cycles -> M_DBus nonzero only while M_select = 1, rsp_err 0, M_request high for 6 cycles.
REQ-024 errAck and xferAck in the same cycle -> rsp_err 1, rsp_data 0.
REQ-025 Retry five times with C_MAX_RETRIES = 4 -> four re-requests followed by rsp_err 1. Retry twice then xferAck -> rsp_err 0.
REQ-026 Reset asserted mid-XFER -> M_select 0 with no clock edge, no rsp_valid, cmd_ready 1. A following command completes normally.

Source files
------------

// File: rtl/opb_master_single.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : opb_master_single                                       |
// | Function : Single-beat OPB bus master. Accepts one user command,   |
// |            arbitrates for the bus, runs the transfer with retry    |
// |            handling and returns a one-cycle response pulse.        |
// |            User bit 31 maps to OPB bit 0 on every bus.             |
// | Options  : define OPB_MASTER_BUSLOCK_EN to hold M_busLock high     |
// |            through the request/transfer phases, including retries. |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module opb_master_single #(
  parameter int C_OPB_AWIDTH  = 32,
  parameter int C_OPB_DWIDTH  = 32,
  parameter int C_MAX_RETRIES = 4
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
  input  logic [C_OPB_DWIDTH-1:0]   cmd_data,
  input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
  output logic                      rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]   rsp_data,
  output logic                      rsp_err,
  output logic                      M_request,
  output logic                      M_select,
  output logic                      M_RNW,
  output logic [0:C_OPB_AWIDTH-1]   M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1] M_BE,
  output logic [0:C_OPB_DWIDTH-1]   M_DBus,
  output logic                      M_seqAddr,
  output logic                      M_busLock,
  input  logic                      OPB_MGrant,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_timeout
);

  localparam int BEW = C_OPB_DWIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // A retry seen while the count already equals this limit would exceed it.
  localparam logic [3:0] RETRY_LIMIT = 4'(C_MAX_RETRIES);

  logic [1:0]              state_q, state_d;
  logic [3:0]              retry_cnt_q, retry_cnt_d;
  logic                    cmd_rnw_q, cmd_rnw_d;
  logic [C_OPB_AWIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [C_OPB_DWIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [BEW-1:0]          cmd_be_q, cmd_be_d;

  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [C_OPB_DWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    m_request_q, m_request_d;
  logic                    m_select_q, m_select_d;
  logic                    m_rnw_q, m_rnw_d;
  logic [C_OPB_AWIDTH-1:0] m_abus_q, m_abus_d;
  logic [BEW-1:0]          m_be_q, m_be_d;
  logic [C_OPB_DWIDTH-1:0] m_dbus_q, m_dbus_d;
  logic                    m_buslock_q, m_buslock_d;

  // State, command copy and every output flop; reset returns to an idle, ready bus.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q     <= ST_IDLE;
      retry_cnt_q <= '0;
      cmd_rnw_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_be_q    <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      m_request_q <= 1'b0;
      m_select_q  <= 1'b0;
      m_rnw_q     <= 1'b0;
      m_abus_q    <= '0;
      m_be_q      <= '0;
      m_dbus_q    <= '0;
      m_buslock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      cmd_rnw_q   <= cmd_rnw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_be_q    <= cmd_be_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      m_request_q <= m_request_d;
      m_select_q  <= m_select_d;
      m_rnw_q     <= m_rnw_d;
      m_abus_q    <= m_abus_d;
      m_be_q      <= m_be_d;
      m_dbus_q    <= m_dbus_d;
      m_buslock_q <= m_buslock_d;
    end
  end

  // Next state, command latch, retry counting and response capture.
  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    cmd_rnw_d   = cmd_rnw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_be_d    = cmd_be_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_rnw_d   = cmd_rnw;
          cmd_addr_d  = cmd_addr;
          cmd_data_d  = cmd_data;
          cmd_be_d    = cmd_be;
          retry_cnt_d = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (OPB_MGrant) state_d = ST_XFER;
      end
      ST_XFER: begin
        // Errors win over a simultaneous ack; ack wins over retry.
        if (OPB_errAck || OPB_timeout) begin
          state_d    = ST_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (OPB_xferAck) begin
          state_d    = ST_RESP;
          rsp_err_d  = 1'b0;
          // Declared [0:N-1], so positional copy lands OPB bit 0 on user bit N-1.
          rsp_data_d = cmd_rnw_q ? OPB_DBus : '0;
        end else if (OPB_retry) begin
          if (retry_cnt_q >= RETRY_LIMIT) begin
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d     = ST_REQ;
            retry_cnt_d = retry_cnt_q + 4'd1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state; bus drives are 0 unless selected.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    m_request_d = (state_d == ST_REQ);
    m_select_d  = (state_d == ST_XFER);
    m_rnw_d     = m_select_d ? cmd_rnw_q : 1'b0;
    m_abus_d    = m_select_d ? cmd_addr_q : '0;
    m_be_d      = m_select_d ? cmd_be_q : '0;
    m_dbus_d    = (m_select_d && !cmd_rnw_q) ? cmd_data_q : '0;
`ifdef OPB_MASTER_BUSLOCK_EN
    m_buslock_d = (state_d == ST_REQ) || (state_d == ST_XFER);
`else
    m_buslock_d = 1'b0;
`endif
  end

  // [N-1:0] flops onto [0:N-1] ports: positional copy gives the bit reversal.
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign M_request = m_request_q;
  assign M_select  = m_select_q;
  assign M_RNW     = m_rnw_q;
  assign M_ABus    = m_abus_q;
  assign M_BE      = m_be_q;
  assign M_DBus    = m_dbus_q;
  assign M_seqAddr = 1'b0;
  assign M_busLock = m_buslock_q;

endmodule
`default_nettype wire

// File: tb/tb_opb_master_single.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_opb_master_single                                    |
// | Function : Self-checking bench for opb_master_single: table of     |
// |            transfers against a behavioural OPB slave, response     |
// |            scoreboard, and a hand-written reset-mid-transfer case. |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_opb_master_single;

  localparam int C_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        M_request, M_select, M_RNW, M_seqAddr, M_busLock;
  logic [0:31] M_ABus, M_DBus, OPB_DBus;
  logic [0:3]  M_BE;
  logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout;

  opb_master_single #(
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_MAX_RETRIES(C_MAX)
  ) dut (
    .OPB_Clk    (clk),
    .OPB_Rst_n  (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rnw    (cmd_rnw),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_be     (cmd_be),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .M_request  (M_request),
    .M_select   (M_select),
    .M_RNW      (M_RNW),
    .M_ABus     (M_ABus),
    .M_BE       (M_BE),
    .M_DBus     (M_DBus),
    .M_seqAddr  (M_seqAddr),
    .M_busLock  (M_busLock),
    .OPB_MGrant (OPB_MGrant),
    .OPB_DBus   (OPB_DBus),
    .OPB_xferAck(OPB_xferAck),
    .OPB_errAck (OPB_errAck),
    .OPB_retry  (OPB_retry),
    .OPB_timeout(OPB_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // fin: 0 xferAck, 1 errAck, 2 timeout, 3 errAck+xferAck together
  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          delay;
    int          wait_n;
    int          nret;
    int          fin;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_data;
    bit          noise;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          offer_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  localparam int NV = 9;
  vec_t vecs[NV];

  // Response monitor and per-cycle bus rules.
  initial begin : monitor
    logic        prev_rv;
    logic [31:0] last_data;
    logic        last_err;
    exp_t        e;
    prev_rv   = 1'b0;
    last_data = '0;
    last_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rv   = 1'b0;
        last_data = '0;
        last_err  = 1'b0;
      end else begin
        chk("seq_addr_zero", M_seqAddr, 0);
`ifdef OPB_MASTER_BUSLOCK_EN
        chk("bus_lock", M_busLock, M_request | M_select);
`else
        chk("bus_lock", M_busLock, 0);
`endif
        if (!M_select) begin
          chk("orbus_rnw", M_RNW, 0);
          chk("orbus_abus", M_ABus, 0);
          chk("orbus_be", M_BE, 0);
          chk("orbus_dbus", M_DBus, 0);
        end else if (M_RNW) begin
          chk("read_dbus_zero", M_DBus, 0);
        end
        if (rsp_valid) begin
          chk("rsp_one_cycle", prev_rv, 0);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid with no outstanding command (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_latency", cyc - e.offer_cyc + 1, e.lat);
          end
          last_data = rsp_data;
          last_err  = rsp_err;
        end else begin
          chk("rsp_data_hold", rsp_data, last_data);
          chk("rsp_err_hold", rsp_err, last_err);
        end
        prev_rv = rsp_valid;
      end
    end
  end

  // Offer one command and play the OPB slave for it.
  task automatic run_vec(input vec_t v);
    int attempts;
    int req_cnt;
    int rereq;
    logic [31:0] exp_dbus;
    attempts = (v.nret > C_MAX) ? C_MAX + 1 : v.nret + 1;
    exp_dbus = v.rnw ? 32'h0 : v.data;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rnw   = v.rnw;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    cmd_be    = v.be;
    sb.push_back('{data: v.exp_data, err: v.exp_err, offer_cyc: cyc,
                   lat: 2 + attempts * (v.delay + v.wait_n + 2)});
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rnw   = ~v.rnw;
    cmd_addr  = ~v.addr;
    cmd_data  = ~v.data;
    cmd_be    = ~v.be;
    chk("busy_cmd_ready", cmd_ready, 0);
    rereq = 0;
    for (int a = 0; a < attempts; a++) begin
      req_cnt = 0;
      for (int d = 0; d < v.delay; d++) begin
        if (M_request === 1'b1) req_cnt++;
        if (v.noise)
          {OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout} = 4'($urandom_range(1, 15));
        @(negedge clk);
      end
      {OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout} = 4'b0;
      if (M_request === 1'b1) req_cnt++;
      if (a > 0 && req_cnt > 0) rereq++;
      chk("req_cycles", req_cnt, v.delay + 1);
      OPB_MGrant = 1'b1;
      @(negedge clk);
      OPB_MGrant = 1'b0;
      chk("request_dropped", M_request, 0);
      for (int w = 0; w <= v.wait_n; w++) begin
        chk("xfer_select", M_select, 1);
        chk("xfer_rnw", M_RNW, v.rnw);
        chk("xfer_abus", M_ABus, v.addr);
        chk("xfer_abus_bit0", M_ABus[0], v.addr[31]);
        chk("xfer_be", M_BE, v.be);
        chk("xfer_dbus", M_DBus, exp_dbus);
        if (w == v.wait_n) begin
          OPB_DBus = v.rdata;
          if (a < attempts - 1 || v.nret > C_MAX) OPB_retry = 1'b1;
          else begin
            case (v.fin)
              0: OPB_xferAck = 1'b1;
              1: OPB_errAck  = 1'b1;
              2: OPB_timeout = 1'b1;
              default: begin
                OPB_errAck  = 1'b1;
                OPB_xferAck = 1'b1;
              end
            endcase
          end
        end
        @(negedge clk);
      end
      {OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout} = 4'b0;
      OPB_DBus = '0;
    end
    chk("rereq_count", rereq, (v.nret > C_MAX) ? C_MAX : v.nret);
    chk("rsp_valid_after_end", rsp_valid, 1);
    chk("resp_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("rsp_valid_low", rsp_valid, 0);
    chk("back_to_idle", cmd_ready, 1);
  endtask

  // Reset asserted between clock edges while the transfer is selected.
  task automatic reset_mid_xfer();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rnw   = 1'b1;
    cmd_addr  = 32'h0000_0040;
    cmd_data  = 32'h0;
    cmd_be    = 4'hF;
    @(negedge clk);
    cmd_valid  = 1'b0;
    OPB_MGrant = 1'b1;
    @(negedge clk);
    OPB_MGrant = 1'b0;
    chk("pre_rst_select", M_select, 1);
    OPB_xferAck = 1'b1;
    OPB_DBus    = 32'hFFFF_0000;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_select", M_select, 0);
    chk("async_rst_request", M_request, 0);
    chk("async_rst_cmd_ready", cmd_ready, 1);
    chk("async_rst_abus", M_ABus, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("rst_held_rsp_valid", rsp_valid, 0);
    chk("rst_held_cmd_ready", cmd_ready, 1);
    OPB_xferAck = 1'b0;
    OPB_DBus    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    cmd_valid   = 1'b0;
    cmd_rnw     = 1'b0;
    cmd_addr    = '0;
    cmd_data    = '0;
    cmd_be      = '0;
    OPB_MGrant  = 1'b0;
    OPB_DBus    = '0;
    OPB_xferAck = 1'b0;
    OPB_errAck  = 1'b0;
    OPB_retry   = 1'b0;
    OPB_timeout = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_request", M_request, 0);
    chk("rst_select", M_select, 0);
    chk("rst_abus", M_ABus, 0);
    chk("rst_dbus", M_DBus, 0);
    chk("rst_buslock", M_busLock, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //          rnw   addr          data          be    dly wt nret fin rdata         err   exp_data      noise
    vecs[0] = '{1'b1, 32'h0100_0100, 32'hFFFF_FFFF, 4'hF, 0, 0, 0,   0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 4'hF, 5, 0, 0,   0, 32'h5555_AAAA, 1'b0, 32'h0,         1'b1};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h0,         4'hF, 0, 0, 0,   3, 32'hA5A5_A5A5, 1'b1, 32'h0,         1'b0};
    vecs[3] = '{1'b1, 32'h2000_0008, 32'h0,         4'hF, 0, 0, 5,   0, 32'h1111_1111, 1'b1, 32'h0,         1'b0};
    vecs[4] = '{1'b0, 32'h0000_0300, 32'h0BAD_F00D, 4'h3, 1, 0, 2,   0, 32'h7777_7777, 1'b0, 32'h0,         1'b1};
    vecs[5] = '{1'b1, 32'h0000_0400, 32'h0,         4'hC, 0, 2, 0,   2, 32'h2222_2222, 1'b1, 32'h0,         1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         4'hF, 1, 1, 4,   0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 4'h8, 0, 0, 0,   1, 32'h3333_3333, 1'b1, 32'h0,         1'b0};
    vecs[8] = '{1'b1, 32'h8000_0001, 32'h0,         4'h1, 2, 3, 0,   0, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1};

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    reset_mid_xfer();
    run_vec(vecs[0]);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
